byte_bit_port_adapter: RTL and testbench

Sequencer that turns one byte-wide host access into eight consecutive single-bit accesses on one port of the dual-port semaphore bit memory. It provides the byte-write / bit-read semaphore path on port 1 (and byte access to plain bit memory). It sits directly upstream of the bit memory: it drives A/DI/WE/OE and honours the memory's WT ready signal.

---
 rtl/byte_bit_port_adapter_pkg.sv | 26 ++
 rtl/byte_bit_port_adapter_wt.sv | 31 +++
 rtl/byte_bit_port_adapter.sv | 122 ++++++++++++
 tb/tb_byte_bit_port_adapter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/byte_bit_port_adapter_pkg.sv
// Shared definitions for the byte-to-bit port adapter: state encoding, address widths
// and the semaphore byte addresses that hosts use on port 1.
package byte_bit_port_adapter_pkg;

  localparam int unsigned BIT_AW  = 12;
  localparam int unsigned BYTE_AW = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BIT,
    S_RD_BIT,
    S_RD_CAP,
    S_DONE
  } state_t;

  // BADR[1] selects the release half of the port-1 semaphore byte (bit address bit 4).
  localparam int unsigned        SEM_REL_SEL_BIT = 1;
  localparam logic [BYTE_AW-1:0] SEM_P1_ACQ_BADR = 9'b1000_0000_1;
  localparam logic [BYTE_AW-1:0] SEM_P1_REL_BADR = 9'b1000_0001_1;

  function automatic logic [BIT_AW-1:0] bit_addr(input logic [BYTE_AW-1:0] badr,
                                                 input logic [2:0]         idx);
    return {badr, idx};
  endfunction

endpackage

// File: rtl/byte_bit_port_adapter_wt.sv
// Stall counter: counts consecutive WT-low cycles and flags the last allowed one.
module wt_timeout_cnt #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = $clog2(TMO_CYC + 1);
  localparam logic [W-1:0] TC_VAL = W'(TMO_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // High during the TMO_CYC-th consecutive stall cycle.
  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/byte_bit_port_adapter.sv
// Sequences one byte-wide host access into eight single-bit accesses on a bit-memory port.
module byte_bit_port_adapter
  import byte_bit_port_adapter_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               REQ,
  input  logic               RNW,
  input  logic [BYTE_AW-1:0] BADR,
  input  logic [7:0]         DIN,
  output logic [7:0]         DOUT,
  output logic               ACK,
  output logic               ERR,
  output logic               BUSY,
  output logic [BIT_AW-1:0]  A,
  output logic               DI,
  output logic               WE,
  output logic               OE,
  input  logic               DQ,
  input  logic               WT
);

  state_t             state_q;
  logic [BYTE_AW-1:0] badr_q;
  logic [7:0]         din_q;
  logic [2:0]         idx_q;
  logic [7:0]         dout_q;
  logic               ack_q;
  logic               err_q;
  logic               busy_q;

  logic stall, tmo;

  assign stall = ((state_q == S_WR_BIT) || (state_q == S_RD_BIT)) && !WT;

  wt_timeout_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_i  (CLK),
    .rst_ni (CLR),
    .clr_i  (!stall),
    .en_i   (stall),
    .tc_o   (tmo)
  );

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      badr_q  <= '0;
      din_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (REQ) begin
            badr_q  <= BADR;
            din_q   <= DIN;
            idx_q   <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RNW ? S_RD_BIT : S_WR_BIT;
          end
        end
        S_WR_BIT: begin
          if (WT) begin
            if (idx_q == 3'd7) begin
              state_q <= S_DONE;
              ack_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (tmo) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_RD_BIT: begin
          if (WT) begin
            state_q <= S_RD_CAP;
          end else if (tmo) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_RD_CAP: begin
          dout_q[idx_q] <= DQ;
          if (idx_q == 3'd7) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= S_RD_BIT;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ACK is raised on the edge that enters DONE, so it is visible exactly in the DONE cycle.
  assign A    = bit_addr(badr_q, idx_q);
  assign WE   = (state_q == S_WR_BIT);
  assign OE   = (state_q == S_RD_BIT);
  assign DI   = (state_q == S_WR_BIT) && din_q[idx_q];
  assign DOUT = dout_q;
  assign ACK  = ack_q;
  assign ERR  = err_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_byte_bit_port_adapter.sv
// Directed bench: bit-memory model with controllable WT stalls, per-cycle strobe capture.
module tb_byte_bit_port_adapter;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        REQ = 1'b0;
  logic        RNW = 1'b0;
  logic [8:0]  BADR = '0;
  logic [7:0]  DIN = '0;
  logic [7:0]  DOUT;
  logic        ACK, ERR, BUSY;
  logic [11:0] A;
  logic        DI, WE, OE;
  logic        DQ = 1'b0;
  logic        WT = 1'b1;

  byte_bit_port_adapter #(.TMO_CYC(4)) dut (
    .CLK(CLK), .CLR(CLR), .REQ(REQ), .RNW(RNW), .BADR(BADR), .DIN(DIN),
    .DOUT(DOUT), .ACK(ACK), .ERR(ERR), .BUSY(BUSY),
    .A(A), .DI(DI), .WE(WE), .OE(OE), .DQ(DQ), .WT(WT)
  );

  always #5 CLK = ~CLK;

  logic mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = 1'b0;

  always @(posedge CLK) begin
    if (WE && WT) mem[A] <= DI;
    if (OE && WT) DQ <= mem[A];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic        we_on   [0:63];
  logic        oe_on   [0:63];
  logic        busy_on [0:63];
  logic        di_on   [0:63];
  logic [11:0] we_a    [0:63];
  int          ack_cyc, ack_n, we_n, overlap;
  logic        err_ack;
  logic [7:0]  dout_ack;
  logic [11:0] stall_a = '0;
  int          stall_left = 0;

  // Called at #1 after an edge with the DUT idle; the REQ is accepted at the next edge.
  task automatic xfer(input logic rnw, input logic [8:0] badr, input logic [7:0] din,
                      input int ncyc, input int clr_cyc, input int pulse_cyc);
    REQ = 1'b1; RNW = rnw; BADR = badr; DIN = din;
    @(posedge CLK); #1;
    REQ = 1'b0;
    ack_cyc = 0; ack_n = 0; we_n = 0; overlap = 0; err_ack = 1'b0; dout_ack = '0;
    for (int c = 1; c <= ncyc; c++) begin
      we_on[c] = WE; oe_on[c] = OE; busy_on[c] = BUSY; di_on[c] = DI; we_a[c] = A;
      if (WE) we_n++;
      if (WE && OE) overlap++;
      if (ACK) begin
        ack_n++;
        if (ack_cyc == 0) begin
          ack_cyc = c; err_ack = ERR; dout_ack = DOUT;
        end
      end
      CLR = (c == clr_cyc) ? 1'b0 : 1'b1;
      REQ = (c == pulse_cyc);
      if ((WE || OE) && A == stall_a && stall_left > 0) begin
        WT = 1'b0;
        stall_left--;
      end else begin
        WT = 1'b1;
      end
      @(posedge CLK); #1;
    end
    REQ = 1'b0; CLR = 1'b1; WT = 1'b1;
  endtask

  logic [7:0] exp_din;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_A", A, 0);
    check("rst_WE", WE, 0);
    check("rst_OE", OE, 0);
    check("rst_DI", DI, 0);
    check("rst_ACK", ACK, 0);
    check("rst_ERR", ERR, 0);
    check("rst_BUSY", BUSY, 0);
    check("rst_DOUT", DOUT, 0);
    CLR = 1'b1;
    @(posedge CLK); #1;

    // Write 0xA5 to byte 2, WT always ready.
    exp_din = 8'hA5;
    xfer(1'b0, 9'h002, exp_din, 9, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("wr1_we_c%0d", c), we_on[c], 1);
      check($sformatf("wr1_a_c%0d", c), we_a[c], 12'h010 + 12'(c - 1));
      check($sformatf("wr1_di_c%0d", c), di_on[c], exp_din[c-1]);
    end
    check("wr1_we_n", we_n, 8);
    check("wr1_ack_cyc", ack_cyc, 9);
    check("wr1_err", err_ack, 0);
    check("wr1_busy_c1", busy_on[1], 1);
    check("wr1_busy_c9", busy_on[9], 1);
    check("wr1_busy_c10", BUSY, 0);

    // Read byte 2 back.
    xfer(1'b1, 9'h002, 8'h00, 17, 0, 0);
    for (int c = 1; c <= 17; c++)
      check($sformatf("rd1_oe_c%0d", c), oe_on[c], ((c % 2) == 1 && c <= 15) ? 1 : 0);
    check("rd1_ack_cyc", ack_cyc, 17);
    check("rd1_dout", dout_ack, 8'hA5);
    check("rd1_err", err_ack, 0);
    check("rd1_overlap", overlap, 0);

    // Read with WT stuck low on bit 2: abort after 4 stalls.
    stall_a = 12'h012; stall_left = 1000;
    xfer(1'b1, 9'h002, 8'h00, 10, 0, 0);
    stall_left = 0;
    for (int c = 5; c <= 8; c++) begin
      check($sformatf("tmo_oe_c%0d", c), oe_on[c], 1);
      check($sformatf("tmo_a_c%0d", c), we_a[c], 12'h012);
    end
    check("tmo_oe_c9", oe_on[9], 0);
    check("tmo_ack_cyc", ack_cyc, 9);
    check("tmo_err", err_ack, 1);
    check("tmo_dout", dout_ack, 8'h01);
    check("tmo_dout_held", DOUT, 8'h01);
    check("tmo_err_held", ERR, 1);

    // Write 0x3C with 3 stall cycles on bit 4.
    stall_a = 12'h014; stall_left = 3;
    xfer(1'b0, 9'h002, 8'h3C, 12, 0, 0);
    stall_left = 0;
    for (int c = 5; c <= 8; c++) begin
      check($sformatf("wrs_we_c%0d", c), we_on[c], 1);
      check($sformatf("wrs_a_c%0d", c), we_a[c], 12'h014);
      check($sformatf("wrs_di_c%0d", c), di_on[c], 1);
    end
    check("wrs_a_c9", we_a[9], 12'h015);
    check("wrs_ack_cyc", ack_cyc, 12);
    check("wrs_err", err_ack, 0);
    check("wrs_err_clr", ERR, 0);
    xfer(1'b1, 9'h002, 8'h00, 17, 0, 0);
    check("rd2_dout", dout_ack, 8'h3C);

    // CLR low during bit 5 of a write.
    xfer(1'b0, 9'h007, 8'hFF, 12, 6, 0);
    check("clr_we_c6", we_on[6], 1);
    check("clr_a_c6", we_a[6], 12'h03D);
    check("clr_we_c7", we_on[7], 0);
    check("clr_busy_c7", busy_on[7], 0);
    check("clr_ack_n", ack_n, 0);
    check("clr_we_n", we_n, 6);
    xfer(1'b0, 9'h007, 8'h5A, 9, 0, 0);
    check("post_clr_ack_cyc", ack_cyc, 9);
    check("post_clr_err", err_ack, 0);
    xfer(1'b1, 9'h007, 8'h00, 17, 0, 0);
    check("post_clr_rd", dout_ack, 8'h5A);

    // REQ pulsed while busy is ignored.
    xfer(1'b0, 9'h008, 8'h96, 25, 0, 3);
    check("pulse_ack_n", ack_n, 1);
    check("pulse_ack_cyc", ack_cyc, 9);
    check("pulse_we_n", we_n, 8);
    check("pulse_busy_end", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
